// File: rtl/uart_rx_word_packer_pkg.sv
// uart_pkg: shared types and default parameters for the UART RX word packer.
//   pack_state_t       - packer FSM states
//   DEF_FIFO_DEPTH     - default byte FIFO depth (power of two, >= 2)
//   DEF_TIMEOUT_CYCLES - default idle clocks before a partial word is emitted
package uart_pkg;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_OUT     = 1'b1
    } pack_state_t;

    localparam int DEF_FIFO_DEPTH     = 16;
    localparam int DEF_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/uart_rx_word_packer_if.sv
// uart_rx_word_packer_if: byte input side, flush, word output side and FIFO
// level of the word packer, bundled into one interface.
//   slave  - the packer: consumes bytes/flush/word_ready, drives the rest
//   master - the environment: drives bytes/flush/word_ready
import uart_pkg::*;

interface uart_rx_word_packer_if #(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [31:0]      word_data;
    logic [2:0]       word_bytes;
    logic             word_valid;
    logic             word_ready;
    logic [LVL_W-1:0] fifo_level;

    modport slave (
        input  in_data, in_valid, flush, word_ready,
        output in_ready, word_data, word_bytes, word_valid, fifo_level
    );

    modport master (
        output in_data, in_valid, flush, word_ready,
        input  in_ready, word_data, word_bytes, word_valid, fifo_level
    );
endinterface

// File: rtl/uart_rx_word_packer_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO, no bypass (a byte written at one
// edge is visible on rdata only after that edge).
//   clk, rstn     - clock, async active-low reset (pointers/level only)
//   push, wdata   - write strobe and byte; ignored when full
//   pop, rdata    - read strobe; rdata shows the head byte combinationally
//   full, empty   - occupancy flags derived from the registered level
//   level         - current occupancy, 0..DEPTH
import uart_pkg::*;

module uart_byte_fifo #(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push,
    input  logic [7:0]  wdata,
    input  logic        pop,
    output logic [7:0]  rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; only pointers and level define the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_word_packer.sv
// uart_rx_word_packer: buffers received UART bytes in a FIFO and packs them
// little-endian into 32-bit words. A word is emitted when four bytes are
// collected, or earlier with fewer bytes on flush or after an idle timeout.
//   clk, rstn - clock, async active-low reset
//   bus       - slave modport: in_data/in_valid/in_ready byte input, flush,
//               word_data/word_bytes/word_valid/word_ready output, fifo_level
import uart_pkg::*;

module uart_rx_word_packer #(
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rstn,
    uart_rx_word_packer_if.slave  bus
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    pack_state_t      state, state_n;
    logic [1:0]       byte_idx, byte_idx_n;
    logic [31:0]      data_q, data_n;
    logic [2:0]       bytes_q, bytes_n;
    logic [CNT_W-1:0] idle_cnt;
    logic             pop;
    logic             timeout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [AW:0]      fifo_level;

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.in_valid && !fifo_full),
        .wdata (bus.in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign bus.in_ready   = !fifo_full;
    assign bus.fifo_level = fifo_level;
    assign bus.word_valid = (state == S_OUT);
    assign bus.word_data  = data_q;
    assign bus.word_bytes = bytes_q;

    // The counter never passes TIMEOUT_CYCLES-1: at that value the FSM
    // either leaves S_COLLECT or a pop clears it.
    assign timeout = (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_COLLECT;
            byte_idx <= '0;
            data_q   <= '0;
            bytes_q  <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            byte_idx <= byte_idx_n;
            data_q   <= data_n;
            bytes_q  <= bytes_n;
            if (pop || state == S_OUT || byte_idx == 2'd0) idle_cnt <= '0;
            else                                            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        byte_idx_n = byte_idx;
        data_n     = data_q;
        bytes_n    = bytes_q;
        pop        = 1'b0;
        case (state)
            S_COLLECT: begin
                if (!fifo_empty) begin
                    // A pop always wins over flush/timeout.
                    pop                           = 1'b1;
                    data_n[{byte_idx, 3'b000} +: 8] = fifo_rdata;
                    byte_idx_n                    = byte_idx + 1'b1;
                    if (byte_idx == 2'd3) begin
                        state_n = S_OUT;
                        bytes_n = 3'd4;
                    end
                end else if (byte_idx != 2'd0 && (bus.flush || timeout)) begin
                    state_n = S_OUT;
                    bytes_n = {1'b0, byte_idx};
                end
            end
            S_OUT: begin
                if (bus.word_ready) begin
                    state_n    = S_COLLECT;
                    byte_idx_n = '0;
                    data_n     = '0;
                    bytes_n    = '0;
                end
            end
            default: state_n = S_COLLECT;
        endcase
    end
endmodule
